dice_duel_ctrl: RTL and testbench
=================================

# dice_duel_ctrl

Sequential, parametrised successor to the combinational dual-dice comparator: runs a user LED chaser and LFSR-driven machine dice, freezes them on a stop press, sums each side serially and compares the sums. It also keeps saturating win/tie scoreboards across rounds. It sits between the board push-buttons (debounced, single-cycle pulses) and the LED/seven-segment display logic.

## Interface
- NUM_DICE, 2, dice per side (1..16)
- FACES, 6, faces per die, values 1..FACES (2..15)
- SCORE_W, 8, width of each scoreboard counter
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1
- DIE_W (local), clog2(FACES+1); SUM_W (local), clog2(NUM_DICE*FACES+1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse: begin a round (IDLE/DONE only)
- stop  in  1  pulse: freeze dice (ROLL only)
- clear_scores  in  1  synchronous clear of the three scoreboards
- user_dice  out  NUM_DICE*DIE_W  die i at [i*DIE_W +: DIE_W]
- machine_dice  out  NUM_DICE*DIE_W  same packing
- user_sum, machine_sum  out  SUM_W  registered sums
- a_gt_b, a_eq_b, a_lt_b  out  1  user_sum vs machine_sum, one-hot when result_valid
- result_valid  out  1  high in DONE
- busy  out  1  high in ROLL, SUM, CMP
- user_wins, machine_wins, ties  out  SCORE_W  scoreboards

## Operation
- States: IDLE -> ROLL (start) -> SUM (stop) -> CMP (after NUM_DICE cycles) -> DONE -> ROLL (start).
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Shifts left every cycle in every state; fb = l[15]^l[13]^l[12]^l[10] enters bit 0.
- Chaser: counter 1..FACES, set to 1 on entry to ROLL, +1 per ROLL cycle, FACES wraps to 1.
- Machine die i: counter 1..FACES, advances (with wrap) in a ROLL cycle when lfsr[i]==1. Otherwise it holds.
- stop in ROLL: user die i <= ((chaser-1+i) mod FACES)+1; machine_dice outputs <= machine die counters; sums <= 0.
- SUM: cycle k (0..NUM_DICE-1) adds user die k and machine die k to the sums. Sums cannot overflow by construction of SUM_W.
- CMP: flags are registered from the final sums. Exactly one of user_wins/machine_wins/ties increments; it saturates at all-ones.
- DONE: dice, sums and flags hold until the next start. On start they clear to 0 and the state enters ROLL.
- start and stop together in ROLL: stop wins. start is ignored in ROLL/SUM/CMP; stop is ignored outside ROLL.
- clear_scores zeroes all three counters in any state. When it coincides with a CMP increment, the clear wins.
- Reset values: state IDLE; lfsr SEED; chaser and machine die counters 1; dice outputs, sums, flags, result_valid, busy and scoreboards 0.
- Reset mid-round aborts with no scoreboard update.

## Timing
- start sampled at edge E: ROLL from E+1 with chaser=1.
- stop sampled at edge S: dice visible after S; SUM occupies NUM_DICE cycles; CMP takes 1 cycle.
- result_valid and the flags rise after edge S+NUM_DICE+1. The scoreboard updates on the same edge.
- busy is low in the cycle after the CMP edge.
- No combinational input-to-output paths.

## Test plan
- Reset with rst_n=0 for 3 cycles mid-SUM: every output reads its reset value and the state is IDLE. A following round completes normally.
- Defaults, start, then stop when chaser=6: user_dice={1,6} (die1=1, die0=6) and user_sum=7. machine_sum matches the bench LFSR model. result_valid appears exactly 3 cycles after the stop edge, with correct one-hot flags.
- Run 200 rounds with random stop delays 1..40: every sum, flag and scoreboard value matches the model, and user_wins+machine_wins+ties=200.
- SCORE_W=2, force ties (NUM_DICE=1, FACES=2, model-selected stop cycles): ties reaches 3 and holds at 3.
- clear_scores asserted on the CMP edge: all counters read 0 afterwards.
- start with stop in the same ROLL cycle freezes the dice. start during SUM leaves latency unchanged. stop in IDLE or DONE has no effect.

Source files
------------

// File: rtl/dice_duel_ctrl.sv
// Dice duel round controller: user chaser vs LFSR-driven machine dice, serial
// summation, comparison and saturating win/tie scoreboards.
module dice_duel_die #(
  parameter int FACES = 6,
  parameter int DIE_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [DIE_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= DIE_W'(1);
    else if (adv) cnt <= (cnt == DIE_W'(FACES)) ? DIE_W'(1) : cnt + DIE_W'(1);
  end
endmodule

module dice_duel_ctrl #(
  parameter int          NUM_DICE = 2,
  parameter int          FACES    = 6,
  parameter int          SCORE_W  = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  localparam int         DIE_W    = $clog2(FACES + 1),
  localparam int         SUM_W    = $clog2(NUM_DICE * FACES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear_scores,
  output logic [NUM_DICE*DIE_W-1:0] user_dice,
  output logic [NUM_DICE*DIE_W-1:0] machine_dice,
  output logic [SUM_W-1:0]          user_sum,
  output logic [SUM_W-1:0]          machine_sum,
  output logic                      a_gt_b,
  output logic                      a_eq_b,
  output logic                      a_lt_b,
  output logic                      result_valid,
  output logic                      busy,
  output logic [SCORE_W-1:0]        user_wins,
  output logic [SCORE_W-1:0]        machine_wins,
  output logic [SCORE_W-1:0]        ties
);
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam int               IDX_W    = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
  localparam logic [DIE_W-1:0] ONE      = DIE_W'(1);
  localparam logic [DIE_W-1:0] TOP      = DIE_W'(FACES);

  typedef enum logic [2:0] {S_IDLE, S_ROLL, S_SUM, S_CMP, S_DONE} state_t;

  state_t                             state;
  logic [15:0]                        lfsr;
  logic                               fb;
  logic [DIE_W-1:0]                   chaser;
  logic [IDX_W-1:0]                   idx;
  logic [NUM_DICE-1:0][DIE_W-1:0]     mcnt, udie, mdie, ufrz;

  assign fb           = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign user_dice    = udie;
  assign machine_dice = mdie;

  // Each machine die is its own free-running counter, gated by one LFSR bit.
  for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
    dice_duel_die #(.FACES(FACES), .DIE_W(DIE_W)) u_die (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  ((state == S_ROLL) && lfsr[i]),
      .cnt  (mcnt[i])
    );
  end

  // User dice are consecutive faces starting at the chaser position.
  always_comb begin
    ufrz = '0;
    for (int i = 0; i < NUM_DICE; i++)
      ufrz[i] = DIE_W'(((int'(chaser) - 1 + i) % FACES) + 1);
  end

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lfsr         <= SEED_EFF;
      chaser       <= ONE;
      idx          <= '0;
      udie         <= '0;
      mdie         <= '0;
      user_sum     <= '0;
      machine_sum  <= '0;
      a_gt_b       <= 1'b0;
      a_eq_b       <= 1'b0;
      a_lt_b       <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      user_wins    <= '0;
      machine_wins <= '0;
      ties         <= '0;
    end else begin
      lfsr <= {lfsr[14:0], fb};
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state        <= S_ROLL;
          chaser       <= ONE;
          udie         <= '0;
          mdie         <= '0;
          user_sum     <= '0;
          machine_sum  <= '0;
          a_gt_b       <= 1'b0;
          a_eq_b       <= 1'b0;
          a_lt_b       <= 1'b0;
          result_valid <= 1'b0;
          busy         <= 1'b1;
        end
        S_ROLL: begin
          chaser <= (chaser == TOP) ? ONE : chaser + ONE;
          if (stop) begin
            udie        <= ufrz;
            mdie        <= mcnt;
            user_sum    <= '0;
            machine_sum <= '0;
            idx         <= '0;
            state       <= S_SUM;
          end
        end
        S_SUM: begin
          user_sum    <= user_sum + SUM_W'(udie[idx]);
          machine_sum <= machine_sum + SUM_W'(mdie[idx]);
          if (idx == IDX_W'(NUM_DICE - 1)) state <= S_CMP;
          else                             idx   <= idx + IDX_W'(1);
        end
        S_CMP: begin
          a_gt_b       <= user_sum > machine_sum;
          a_eq_b       <= user_sum == machine_sum;
          a_lt_b       <= user_sum < machine_sum;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_DONE;
          if (user_sum > machine_sum)       user_wins    <= sat_inc(user_wins);
          else if (user_sum < machine_sum)  machine_wins <= sat_inc(machine_wins);
          else                              ties         <= sat_inc(ties);
        end
        default: state <= S_IDLE;
      endcase
      // Placed last so a clear beats a same-cycle CMP increment.
      if (clear_scores) begin
        user_wins    <= '0;
        machine_wins <= '0;
        ties         <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dice_duel_ctrl.sv
// Directed bench: default-parameter DUT plus a tiny 1-die/2-face DUT for saturation.
module tb_dice_duel_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic go[2], halt[2], clr[2];
  always #5 clk = ~clk;

  logic [5:0] a_ud, a_md;  logic [3:0] a_us, a_ms;  logic [7:0] a_uw, a_mw, a_ti;
  logic       a_gt, a_eq, a_lt, a_rv, a_busy;
  logic [1:0] b_ud, b_md, b_us, b_ms, b_uw, b_mw, b_ti;
  logic       b_gt, b_eq, b_lt, b_rv, b_busy;

  dice_duel_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(go[0]), .stop(halt[0]), .clear_scores(clr[0]),
    .user_dice(a_ud), .machine_dice(a_md), .user_sum(a_us), .machine_sum(a_ms),
    .a_gt_b(a_gt), .a_eq_b(a_eq), .a_lt_b(a_lt), .result_valid(a_rv), .busy(a_busy),
    .user_wins(a_uw), .machine_wins(a_mw), .ties(a_ti));

  dice_duel_ctrl #(.NUM_DICE(1), .FACES(2), .SCORE_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(go[1]), .stop(halt[1]), .clear_scores(clr[1]),
    .user_dice(b_ud), .machine_dice(b_md), .user_sum(b_us), .machine_sum(b_ms),
    .a_gt_b(b_gt), .a_eq_b(b_eq), .a_lt_b(b_lt), .result_valid(b_rv), .busy(b_busy),
    .user_wins(b_uw), .machine_wins(b_mw), .ties(b_ti));

  int tests = 0, fails = 0;
  const int ND[2] = '{2, 1}, FC[2] = '{6, 2}, SMAX[2] = '{255, 3}, DW[2] = '{3, 2};

  // Reference model; state codes 0 idle, 1 roll, 2 sum, 3 cmp, 4 done.
  logic [15:0] m_lfsr[2];
  int m_st[2], m_ch[2], m_k[2], m_us[2], m_ms[2], m_uw[2], m_mw[2], m_ti[2];
  int m_md[2][2], m_ud[2][2], m_mo[2][2];
  bit m_gt[2], m_eq[2], m_lt[2], m_rv[2];

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d);
    logic [15:0] l;
    l = m_lfsr[d];
    if (!rst_n) begin
      m_st[d] = 0; m_lfsr[d] = 16'hACE1; m_ch[d] = 1; m_k[d] = 0;
      m_us[d] = 0; m_ms[d] = 0; m_uw[d] = 0; m_mw[d] = 0; m_ti[d] = 0;
      m_gt[d] = 0; m_eq[d] = 0; m_lt[d] = 0; m_rv[d] = 0;
      for (int i = 0; i < 2; i++) begin m_md[d][i] = 1; m_ud[d][i] = 0; m_mo[d][i] = 0; end
      return;
    end
    case (m_st[d])
      0, 4: if (go[d]) begin
        m_st[d] = 1; m_ch[d] = 1; m_us[d] = 0; m_ms[d] = 0;
        m_gt[d] = 0; m_eq[d] = 0; m_lt[d] = 0; m_rv[d] = 0;
        for (int i = 0; i < 2; i++) begin m_ud[d][i] = 0; m_mo[d][i] = 0; end
      end
      1: begin
        if (halt[d]) begin
          for (int i = 0; i < ND[d]; i++) begin
            m_ud[d][i] = ((m_ch[d] - 1 + i) % FC[d]) + 1;
            m_mo[d][i] = m_md[d][i];
          end
          m_us[d] = 0; m_ms[d] = 0; m_k[d] = 0; m_st[d] = 2;
        end
        for (int i = 0; i < ND[d]; i++)
          if (l[i]) m_md[d][i] = (m_md[d][i] == FC[d]) ? 1 : m_md[d][i] + 1;
        m_ch[d] = (m_ch[d] == FC[d]) ? 1 : m_ch[d] + 1;
      end
      2: begin
        m_us[d] += m_ud[d][m_k[d]];
        m_ms[d] += m_mo[d][m_k[d]];
        if (m_k[d] == ND[d] - 1) m_st[d] = 3; else m_k[d]++;
      end
      3: begin
        m_gt[d] = m_us[d] > m_ms[d];
        m_eq[d] = m_us[d] == m_ms[d];
        m_lt[d] = m_us[d] < m_ms[d];
        m_rv[d] = 1; m_st[d] = 4;
        if (m_gt[d] && m_uw[d] < SMAX[d]) m_uw[d]++;
        if (m_lt[d] && m_mw[d] < SMAX[d]) m_mw[d]++;
        if (m_eq[d] && m_ti[d] < SMAX[d]) m_ti[d]++;
      end
      default: ;
    endcase
    if (clr[d]) begin m_uw[d] = 0; m_mw[d] = 0; m_ti[d] = 0; end
    m_lfsr[d] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk); #1;
  endtask

  task automatic check_dut(input int d, input string tag);
    logic [63:0] eu, em;
    eu = 0; em = 0;
    for (int i = 0; i < ND[d]; i++) begin
      eu |= 64'(m_ud[d][i]) << (i * DW[d]);
      em |= 64'(m_mo[d][i]) << (i * DW[d]);
    end
    cmp({tag, ".user_dice"},    d ? b_ud : a_ud, eu);
    cmp({tag, ".machine_dice"}, d ? b_md : a_md, em);
    cmp({tag, ".user_sum"},     d ? b_us : a_us, 64'(m_us[d]));
    cmp({tag, ".machine_sum"},  d ? b_ms : a_ms, 64'(m_ms[d]));
    cmp({tag, ".flags"}, d ? {b_gt, b_eq, b_lt} : {a_gt, a_eq, a_lt},
        {m_gt[d], m_eq[d], m_lt[d]});
    cmp({tag, ".result_valid"}, d ? b_rv : a_rv, 64'(m_rv[d]));
    cmp({tag, ".busy"}, d ? b_busy : a_busy, 64'(m_st[d] >= 1 && m_st[d] <= 3));
    cmp({tag, ".user_wins"},    d ? b_uw : a_uw, 64'(m_uw[d]));
    cmp({tag, ".machine_wins"}, d ? b_mw : a_mw, 64'(m_mw[d]));
    cmp({tag, ".ties"},         d ? b_ti : a_ti, 64'(m_ti[d]));
  endtask

  task automatic round_a(input int dly);
    go[0] = 1; tick(); go[0] = 0;
    repeat (dly - 1) tick();
    halt[0] = 1; tick(); halt[0] = 0;
    repeat (3) tick();
  endtask

  initial begin
    int n;
    rst_n = 0;
    for (int d = 0; d < 2; d++) begin go[d] = 0; halt[d] = 0; clr[d] = 0; end
    repeat (3) tick();
    check_dut(0, "por_a");
    check_dut(1, "por_b");
    rst_n = 1;

    // stop while idle is ignored
    halt[0] = 1; tick(); halt[0] = 0;
    cmp("idle_stop.busy", a_busy, 0);
    check_dut(0, "idle_stop");

    // directed round, stop at chaser = 6
    go[0] = 1; tick(); go[0] = 0;
    cmp("roll.busy", a_busy, 1);
    n = 0;
    while (m_ch[0] != 6 && n < 20) begin tick(); n++; end
    cmp("chaser_wait", n, 5);
    halt[0] = 1; tick(); halt[0] = 0;
    cmp("dir.user_dice", a_ud, 6'b001_110);
    cmp("dir.rv_s1", a_rv, 0);
    tick(); tick();
    cmp("dir.rv_s2", a_rv, 0);
    tick();
    cmp("dir.rv_s3", a_rv, 1);
    cmp("dir.user_sum", a_us, 7);
    cmp("dir.onehot", $onehot({a_gt, a_eq, a_lt}), 1);
    cmp("dir.busy", a_busy, 0);
    check_dut(0, "dir");

    // stop in DONE is ignored
    halt[0] = 1; tick(); halt[0] = 0;
    cmp("done_stop.rv", a_rv, 1);
    check_dut(0, "done_stop");

    // reset held 3 cycles in the middle of SUM
    go[0] = 1; tick(); go[0] = 0;
    repeat (3) tick();
    halt[0] = 1; tick(); halt[0] = 0;
    tick();
    rst_n = 0; repeat (3) tick(); rst_n = 1;
    cmp("midrst.busy", a_busy, 0);
    cmp("midrst.user_dice", a_ud, 0);
    cmp("midrst.scores", {a_uw, a_mw, a_ti}, 0);
    check_dut(0, "midrst");
    round_a(7);
    cmp("post_rst.rv", a_rv, 1);
    check_dut(0, "post_rst");

    // start+stop together stops; start during SUM is ignored
    go[0] = 1; tick(); go[0] = 0;
    repeat (4) tick();
    go[0] = 1; halt[0] = 1; tick(); go[0] = 0; halt[0] = 0;
    cmp("ss.busy", a_busy, 1);
    check_dut(0, "ss");
    go[0] = 1; tick(); go[0] = 0;
    tick();
    cmp("sum_start.rv_s2", a_rv, 0);
    tick();
    cmp("sum_start.rv_s3", a_rv, 1);
    check_dut(0, "sum_start");

    // clear_scores on the CMP edge wins
    go[0] = 1; tick(); go[0] = 0;
    repeat (2) tick();
    halt[0] = 1; tick(); halt[0] = 0;
    repeat (2) tick();
    clr[0] = 1; tick(); clr[0] = 0;
    cmp("clr_cmp.scores", {a_uw, a_mw, a_ti}, 0);
    cmp("clr_cmp.rv", a_rv, 1);
    check_dut(0, "clr_cmp");

    // random stop delays
    for (int r = 0; r < 200; r++) begin
      round_a(int'($urandom_range(1, 40)));
      check_dut(0, $sformatf("rnd%0d", r));
    end
    cmp("rnd.total", 32'(a_uw) + 32'(a_mw) + 32'(a_ti), 200);

    // forced ties on the small DUT saturate at 3
    for (int r = 0; r < 5; r++) begin
      go[1] = 1; tick(); go[1] = 0;
      n = 0;
      while (m_ch[1] != m_md[1][0] && n < 100) begin tick(); n++; end
      cmp($sformatf("tie%0d.found", r), n < 100, 1);
      halt[1] = 1; tick(); halt[1] = 0;
      repeat (2) tick();
      cmp($sformatf("tie%0d.eq", r), b_eq, 1);
      cmp($sformatf("tie%0d.ties", r), b_ti, (r < 3) ? r + 1 : 3);
      check_dut(1, $sformatf("tie%0d", r));
    end
    cmp("tie.sat", b_ti, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
